// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the LDR and ALU
//   writeback stages. Age order is queue head (oldest) > LDR > ALU. The
//   oldest candidate is written each cycle. Younger same-cycle requests
//   are parked in an in-order write queue.
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     w_en_ldr/ldr_addr/ldr_data    LDR writeback request
//     w_en_alu/alu_addr/alu_data    ALU writeback request
//     rf_w_en/rf_w_addr/rf_w_data   registered register-file write port
//     byp_addr/byp_hit/byp_data     decode bypass lookup (combinational)
//     stall                         registered back-pressure to the front end
//     overflow                      sticky: a request was dropped on a full queue
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en_ldr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  input  logic              w_en_alu,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [ADDR_W-1:0] byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
  output logic              stall,
  output logic              overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;

  logic              has_q, issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              r0_v, r1_v, acc0, acc1, drop;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_data, r1_data;
  logic [CW-1:0]     occ, count_next;
  logic [PW-1:0]     slot1;

  always_comb begin
    has_q      = (count != '0);
    issue_en   = has_q | w_en_ldr | w_en_alu;
    issue_addr = '0;
    issue_data = '0;
    r0_v       = 1'b0;
    r0_addr    = ldr_addr;
    r0_data    = ldr_data;
    r1_v       = 1'b0;
    r1_addr    = alu_addr;
    r1_data    = alu_data;
    if (has_q) begin
      issue_addr = mem_addr[head];
      issue_data = mem_data[head];
      r0_v       = w_en_ldr;
      r1_v       = w_en_alu;
    end else if (w_en_ldr) begin
      issue_addr = ldr_addr;
      issue_data = ldr_data;
      r0_v       = w_en_alu;
      r0_addr    = alu_addr;
      r0_data    = alu_data;
    end else if (w_en_alu) begin
      issue_addr = alu_addr;
      issue_data = alu_data;
    end
    // Occupancy after this cycle's pop; the freed head slot may be reused.
    occ        = count - CW'(has_q);
    acc0       = r0_v && (occ < DEPTH_C);
    acc1       = r1_v && ((occ + CW'(acc0)) < DEPTH_C);
    slot1      = tail + PW'(acc0);
    drop       = (r0_v & ~acc0) | (r1_v & ~acc1);
    count_next = occ + CW'(acc0) + CW'(acc1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      stall     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      head    <= head + PW'(has_q);
      tail    <= tail + PW'(acc0) + PW'(acc1);
      count   <= count_next;
      rf_w_en <= issue_en;
      if (issue_en) begin
        rf_w_addr <= issue_addr;
        rf_w_data <= issue_data;
      end
      stall <= (count_next >= STALL_TH);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (acc0) begin
      mem_addr[tail] <= r0_addr;
      mem_data[tail] <= r0_data;
    end
    if (acc1) begin
      mem_addr[slot1] <= r1_addr;
      mem_data[slot1] <= r1_data;
    end
  end

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (rf_w_en && (rf_w_addr == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = rf_w_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (mem_addr[head + PW'(i)] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = mem_data[head + PW'(i)];
      end
    end
  end
endmodule
